// File: rtl/out_pack_writer.sv
// out_pack_writer
// Downstream stage of the bilinear core. Packs the per-pixel byte write
// stream into 32-bit little-endian words with byte enables, buffers them in
// a first-word-fall-through FIFO and presents them on a valid/ready write
// port. flush emits any partial word; flush_done pulses once everything
// flushed has drained.
// Optional: define OUT_PACK_PERF_EN to add the perf_words / perf_stall
// saturating counters.
module out_pack_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_data,
    output logic [3:0]        m_be,
    output logic              busy,
    output logic              overflow,
    output logic              flush_done
`ifdef OUT_PACK_PERF_EN
    ,
    output logic [31:0]       perf_words,
    output logic [31:0]       perf_stall
`endif
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int WA_W = ADDR_W - 2;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    // Write one byte lane of a little-endian word.
    function automatic logic [31:0] lane_write(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  value);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = value;
            2'd1:    res[15:8]  = value;
            2'd2:    res[23:16] = value;
            default: res[31:24] = value;
        endcase
        return res;
    endfunction

    // Pack register and control state
    logic            pack_valid_r;
    logic [WA_W-1:0] pack_waddr_r;
    logic [31:0]     pack_data_r;
    logic [3:0]      pack_be_r;
    logic            flush_pending_r;
    logic            armed_r;
    logic            overflow_r;
    logic            flush_done_r;

    // FIFO state
    logic [WA_W-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [31:0]     fifo_data_r [FIFO_DEPTH];
    logic [3:0]      fifo_be_r   [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW:0]     count_r;

    // Next-state / datapath signals
    logic            srst_s;
    logic [WA_W-1:0] in_waddr_s;
    logic [1:0]      in_lane_s;
    logic [3:0]      lane_be_s;
    logic [31:0]     merged_data_s;
    logic [3:0]      merged_be_s;
    logic            pk_valid_s;
    logic [WA_W-1:0] pk_waddr_s;
    logic [31:0]     pk_data_s;
    logic [3:0]      pk_be_s;
    logic            push_s;
    logic [WA_W-1:0] push_waddr_s;
    logic [31:0]     push_data_s;
    logic [3:0]      push_be_s;
    logic            pending_next_s;
    logic            armed_next_s;
    logic            done_cond_s;
    logic            pop_s;
    logic            full_s;
    logic            wr_en_s;
    logic            drop_s;

    assign srst_s     = !rst_n || clear;
    assign in_waddr_s = in_addr[ADDR_W-1:2];
    assign in_lane_s  = in_addr[1:0];
    assign lane_be_s  = 4'b0001 << in_lane_s;

    assign m_valid    = (count_r != {(PW + 1){1'b0}});
    assign m_addr     = {fifo_addr_r[rd_ptr_r], 2'b00};
    assign m_data     = fifo_data_r[rd_ptr_r];
    assign m_be       = fifo_be_r[rd_ptr_r];
    assign busy       = pack_valid_r || m_valid || flush_pending_r;
    assign overflow   = overflow_r;
    assign flush_done = flush_done_r;

    assign pop_s   = m_valid && m_ready;
    assign full_s  = (count_r == DEPTH_C);
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // Merge the incoming byte, decide the single emit of this cycle and the flush bookkeeping
    always_comb begin
        pk_valid_s     = pack_valid_r;
        pk_waddr_s     = pack_waddr_r;
        pk_data_s      = pack_data_r;
        pk_be_s        = pack_be_r;
        push_s         = 1'b0;
        push_waddr_s   = pack_waddr_r;
        push_data_s    = pack_data_r;
        push_be_s      = pack_be_r;
        pending_next_s = flush_pending_r;
        merged_data_s  = lane_write(pack_valid_r ? pack_data_r : 32'h0, in_lane_s, in_data);
        merged_be_s    = (pack_valid_r ? pack_be_r : 4'h0) | lane_be_s;

        if (in_valid) begin
            if (pack_valid_r && (pack_waddr_r != in_waddr_s)) begin
                // Address discontinuity: old pack goes out, byte starts a fresh pack
                push_s     = 1'b1;
                pk_valid_s = 1'b1;
                pk_waddr_s = in_waddr_s;
                pk_data_s  = lane_write(32'h0, in_lane_s, in_data);
                pk_be_s    = lane_be_s;
            end else if (merged_be_s == 4'hF) begin
                // Word completed: emit it straight away
                push_s       = 1'b1;
                push_waddr_s = in_waddr_s;
                push_data_s  = merged_data_s;
                push_be_s    = merged_be_s;
                pk_valid_s   = 1'b0;
                pk_be_s      = 4'h0;
            end else begin
                pk_valid_s = 1'b1;
                pk_waddr_s = in_waddr_s;
                pk_data_s  = merged_data_s;
                pk_be_s    = merged_be_s;
            end
        end else begin
            pk_valid_s = pack_valid_r;
        end

        if (flush || flush_pending_r) begin
            if (push_s) begin
                // Emit slot already taken; retry the remaining pack next cycle
                pending_next_s = 1'b1;
            end else if (pk_valid_s) begin
                pending_next_s = 1'b0;
                push_s         = 1'b1;
                push_waddr_s   = pk_waddr_s;
                push_data_s    = pk_data_s;
                push_be_s      = pk_be_s;
                pk_valid_s     = 1'b0;
                pk_be_s        = 4'h0;
            end else begin
                pending_next_s = 1'b0;
            end
        end else begin
            pending_next_s = flush_pending_r;
        end

        done_cond_s = armed_r && !pack_valid_r && !m_valid && !push_s && !flush_pending_r;

        if (flush) begin
            armed_next_s = 1'b1;
        end else if (done_cond_s) begin
            armed_next_s = 1'b0;
        end else begin
            armed_next_s = armed_r;
        end
    end

    // Pack register, flush/completion tracking and sticky overflow
    always_ff @(posedge clk) begin
        if (srst_s) begin
            pack_valid_r    <= 1'b0;
            pack_waddr_r    <= {WA_W{1'b0}};
            pack_data_r     <= 32'h0;
            pack_be_r       <= 4'h0;
            flush_pending_r <= 1'b0;
            armed_r         <= 1'b0;
            overflow_r      <= 1'b0;
            flush_done_r    <= 1'b0;
        end else begin
            pack_valid_r    <= pk_valid_s;
            pack_waddr_r    <= pk_waddr_s;
            pack_data_r     <= pk_data_s;
            pack_be_r       <= pk_be_s;
            flush_pending_r <= pending_next_s;
            armed_r         <= armed_next_s;
            flush_done_r    <= done_cond_s;
            overflow_r      <= overflow_r || drop_s;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (srst_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + (PW + 1)'(wr_en_s) - (PW + 1)'(pop_s);
        end
    end

    // FIFO storage; contents are only visible through the reset pointers
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            fifo_addr_r[wr_ptr_r] <= push_waddr_s;
            fifo_data_r[wr_ptr_r] <= push_data_s;
            fifo_be_r[wr_ptr_r]   <= push_be_s;
        end
    end

`ifdef OUT_PACK_PERF_EN
    logic [31:0] perf_words_r;
    logic [31:0] perf_stall_r;

    assign perf_words = perf_words_r;
    assign perf_stall = perf_stall_r;

    // Saturating counters of accepted words and stalled cycles
    always_ff @(posedge clk) begin
        if (srst_s) begin
            perf_words_r <= 32'h0;
            perf_stall_r <= 32'h0;
        end else begin
            if (pop_s && (perf_words_r != 32'hFFFF_FFFF)) begin
                perf_words_r <= perf_words_r + 32'h1;
            end
            if (m_valid && !m_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'h1;
            end
        end
    end
`endif

endmodule

// File: doc/out_pack_writer.md
Name: out_pack_writer

Overview:
- Downstream stage of the bilinear core. Consumes its per-pixel byte write stream (valid/addr/data, one byte per two cycles in normal mode).
- Packs bytes into 32-bit little-endian words with byte enables and buffers them in a small FIFO.
- Presents the words on a valid/ready write port toward output BRAM/bus.
- Provides end-of-job flush and a completion pulse, so the controller raises DONE only after every pixel has landed.

Parameters:
- FIFO_DEPTH, 8, word FIFO entries; power of 2, at least 2.
- ADDR_W, 32, byte-address width of in_addr and m_addr.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous job clear; same effect as reset.
- in_valid  in  1  byte write strobe from the core (no backpressure exists on this input).
- in_addr  in  ADDR_W  byte address of the output pixel.
- in_data  in  8  pixel value.
- flush  in  1  one-cycle pulse; emit any partial word.
- m_valid  out  1  word available.
- m_ready  in  1  sink accepts the word.
- m_addr  out  ADDR_W  word-aligned byte address; [1:0] is always 0.
- m_data  out  32  packed word; lane k = bits [8k+7:8k].
- m_be  out  4  byte enables.
- busy  out  1  pack register, FIFO or pending flush is non-empty.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- flush_done  out  1  one-cycle pulse when the flush has fully drained.

Behaviour:
- Reset/clear:
  - All outputs are 0; pack register and FIFO are empty.
  - flush_pending and overflow are cleared.
  - clear has priority over all other inputs in the same cycle.
- Pack register: holds valid, word address (in_addr[ADDR_W-1:2]), data[31:0] and be[3:0].
- On in_valid:
  - If the pack is empty, or holds the same word address: write the lane at in_addr[1:0] and set its be bit. A rewrite of the same lane overwrites the data.
  - If the pack holds a different word address: emit the old pack to the FIFO and load the new byte into a fresh pack.
  - If be becomes 4'hF after a merge: emit the pack in that same cycle; the pack becomes empty.
- At most one FIFO push per cycle.
- flush handling:
  - flush with no conflicting emit in that cycle: a non-empty pack is emitted after merging any same-cycle in_valid byte.
  - If the cycle already has an emit (discontinuity): set flush_pending and emit the remaining pack on the next cycle.
  - flush with an empty pack: only arms completion.
- flush_done: one-cycle pulse on the first cycle where all of these hold:
  - a flush has been seen;
  - pack is empty;
  - FIFO is empty;
  - no push occurs in that cycle.
  - It is then disarmed until the next flush.
- FIFO:
  - First-word-fall-through; m_valid = not empty; head drives m_addr/m_data/m_be.
  - Pop on m_valid && m_ready.
  - Push and pop may occur in the same cycle, including when full: the pop frees the slot and the push succeeds.
- Overflow: a push when full with no pop drops the incoming word and sets overflow; overflow holds until reset or clear. Order of the words kept is preserved.
- Latency: the byte that completes a word at cycle t produces m_valid=1 at t+1 if the FIFO was empty.
- Pointers wrap modulo FIFO_DEPTH. A count of log2(FIFO_DEPTH)+1 bits separates full from empty.
- busy = pack valid | FIFO not empty | flush_pending.
- Reset mid-operation discards all buffered data; no stale word appears afterward.

Optional Feature:
- Macro OUT_PACK_PERF_EN.
- Defined: adds two outputs.
  - perf_words [31:0]: counts accepted pops.
  - perf_stall [31:0]: counts cycles with m_valid && !m_ready.
  - Both saturate at 32'hFFFFFFFF and clear on reset or clear.
- Undefined: these ports and the counter logic do not exist.

Test Plan:
- Sequential full words: m_ready=1; bytes at addr 0..7 with data 0x10..0x17 -> two writes:
  - addr 0x0, data 0x13121110, be 0xF;
  - addr 0x4, data 0x17161514, be 0xF;
  - each m_valid one cycle after its 4th byte; busy=0 afterward.
- Partial flush: bytes at addr 0..5, then flush -> addr 0x0 with be 0xF, then addr 0x4 with be 0x3 and data[15:0]=0x1514; exactly one flush_done pulse after the last pop.
- Discontinuity: bytes at addr 8, 9, then 20 -> addr 0x8 with be 0x3 pushed in the cycle of the addr-20 byte; then flush -> addr 0x14 with be 0x1. Same test with flush in the same cycle as the addr-20 byte -> identical output, flush_pending path exercised.
- Backpressure: FIFO_DEPTH=8, m_ready=0, 40 sequential bytes -> m_valid held, overflow=1 after the 9th completed word; then m_ready=1 -> exactly 8 words at addr 0x0..0x1C, in order.
- Reset mid-job: pack partial and FIFO holding 3 words; rst_n=0 for 1 cycle -> m_valid, busy and overflow are 0; with OUT_PACK_PERF_EN defined, perf_words and perf_stall are 0; no stale word appears on later traffic.
- Perf counters (OUT_PACK_PERF_EN defined): 2 words with m_ready low for 3 cycles -> perf_words=2, perf_stall=3.
